// File: rtl/stream_arb_mux.sv
// Stream arbiter/mux: selects one of CHANNELS valid/ready input streams (round-robin or fixed
// priority), holds that selection for a whole packet, and registers the winning beat.
module stream_arb_mux #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned ROUND_ROBIN = 1,
  localparam int unsigned SW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SW-1:0]             out_sel,
  input  logic                      out_ready
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       lock_ch_q, lock_ch_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic [SW-1:0]       grant_idx, cand;
  logic                grant_any;
  logic [CHANNELS-1:0] grant;
  logic                load, accept, win_last;
  logic [WIDTH-1:0]    win_data;
  logic                valid_q, last_q;
  logic [WIDTH-1:0]    data_q;
  logic [SW-1:0]       sel_q;

  assign load = ~valid_q | out_ready;

  // While locked the grant stays on the packet owner even if it is momentarily not valid.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (state_q == StLocked) begin
      grant_idx = lock_ch_q;
      grant_any = 1'b1;
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (ROUND_ROBIN != 0) begin
          cand = SW'((32'(ptr_q) + k) % CHANNELS);
        end else begin
          cand = SW'(k);
        end
        if (!grant_any && in_valid[cand]) begin
          grant_idx = cand;
          grant_any = 1'b1;
        end
      end
    end
  end

  assign grant    = grant_any ? (CHANNELS'(1) << grant_idx) : '0;
  assign in_ready = (reset && load) ? grant : '0;
  assign accept   = |(in_valid & in_ready);
  assign win_data = in_data[grant_idx*WIDTH +: WIDTH];
  assign win_last = in_last[grant_idx];

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    if (accept) begin
      if (win_last) begin
        state_d = StIdle;
        ptr_d   = (grant_idx == SW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d   = StLocked;
        lock_ch_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      lock_ch_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      if (accept) begin
        valid_q <= 1'b1;
        data_q  <= win_data;
        last_q  <= win_last;
        sel_q   <= grant_idx;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: three configurations driven side by side, every cycle compared
// against a packet-level reference model, plus directed scenario checks.
module tb_stream_arb_mux;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // unit 0: defaults (round robin), unit 1: fixed priority, unit 2: 3 channels x 8 bits
  logic [3:0]  v0, l0, r0, v1, l1, r1;
  logic [15:0] d0, d1;
  logic        ov0, ol0, ordy0, ov1, ol1, ordy1;
  logic [3:0]  od0, od1;
  logic [1:0]  os0, os1;
  logic [2:0]  v2, l2, r2;
  logic [23:0] d2;
  logic        ov2, ol2, ordy2;
  logic [7:0]  od2;
  logic [1:0]  os2;

  stream_arb_mux dut0 (
    .clock(clock), .reset(reset), .in_valid(v0), .in_data(d0), .in_last(l0), .in_ready(r0),
    .out_valid(ov0), .out_data(od0), .out_last(ol0), .out_sel(os0), .out_ready(ordy0)
  );

  stream_arb_mux #(.ROUND_ROBIN(0)) dut1 (
    .clock(clock), .reset(reset), .in_valid(v1), .in_data(d1), .in_last(l1), .in_ready(r1),
    .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_sel(os1), .out_ready(ordy1)
  );

  stream_arb_mux #(.CHANNELS(3), .WIDTH(8)) dut2 (
    .clock(clock), .reset(reset), .in_valid(v2), .in_data(d2), .in_last(l2), .in_ready(r2),
    .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_sel(os2), .out_ready(ordy2)
  );

  localparam int NU = 3;
  int nch   [NU] = '{4, 4, 3};
  int rr    [NU] = '{1, 0, 1};
  int dmask [NU] = '{15, 15, 255};

  int s_v [NU];
  int s_l [NU];
  int s_or[NU];
  int s_d [NU][4];

  // Model: packet owner (-1 = none), rotation pointer, and the single output register.
  int m_ptr [NU];
  int m_lock[NU];
  int m_ov  [NU];
  int m_od  [NU];
  int m_ol  [NU];
  int m_os  [NU];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int u = 0; u < NU; u++) begin
      s_v[u]  = 0;
      s_l[u]  = 0;
      s_or[u] = 1;
      for (int c = 0; c < 4; c++) s_d[u][c] = 0;
    end
  endtask

  task automatic apply();
    for (int c = 0; c < 4; c++) begin
      d0[c*4 +: 4] = 4'(s_d[0][c]);
      d1[c*4 +: 4] = 4'(s_d[1][c]);
    end
    for (int c = 0; c < 3; c++) d2[c*8 +: 8] = 8'(s_d[2][c]);
    v0 = 4'(s_v[0]); l0 = 4'(s_l[0]); ordy0 = s_or[0][0];
    v1 = 4'(s_v[1]); l1 = 4'(s_l[1]); ordy1 = s_or[1][0];
    v2 = 3'(s_v[2]); l2 = 3'(s_l[2]); ordy2 = s_or[2][0];
  endtask

  function automatic logic [31:0] obs_rdy(input int u);
    case (u)
      0:       return 32'(r0);
      1:       return 32'(r1);
      default: return 32'(r2);
    endcase
  endfunction

  function automatic logic [31:0] obs_out(input int u);
    case (u)
      0:       return 32'({ov0, ol0, os0, 4'h0, od0});
      1:       return 32'({ov1, ol1, os1, 4'h0, od1});
      default: return 32'({ov2, ol2, os2, od2});
    endcase
  endfunction

  function automatic logic [31:0] exp_out(input int u);
    return 32'((m_ov[u] << 11) | (m_ol[u] << 10) | (m_os[u] << 8) | m_od[u]);
  endfunction

  function automatic int m_grant(input int u);
    if (m_lock[u] >= 0) return m_lock[u];
    for (int k = 0; k < nch[u]; k++) begin
      int c;
      c = (rr[u] != 0) ? (m_ptr[u] + k) % nch[u] : k;
      if (s_v[u][c]) return c;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g  [NU];
    int acc[NU];
    apply();
    #1;
    for (int u = 0; u < NU; u++) begin
      int exp_r;
      g[u]   = m_grant(u);
      exp_r  = (reset && (m_ov[u] == 0 || s_or[u] != 0) && g[u] >= 0) ? (1 << g[u]) : 0;
      acc[u] = ((exp_r & s_v[u]) != 0) ? 1 : 0;
      chk($sformatf("ready_u%0d", u), obs_rdy(u), 32'(exp_r));
    end
    for (int u = 0; u < NU; u++) begin
      if (!reset) begin
        m_ov[u] = 0; m_od[u] = 0; m_ol[u] = 0; m_os[u] = 0; m_ptr[u] = 0; m_lock[u] = -1;
      end else if (acc[u] != 0) begin
        m_ov[u] = 1;
        m_od[u] = s_d[u][g[u]] & dmask[u];
        m_ol[u] = (s_l[u] >> g[u]) & 1;
        m_os[u] = g[u];
        if (m_ol[u] != 0) begin
          m_ptr[u]  = (g[u] + 1) % nch[u];
          m_lock[u] = -1;
        end else begin
          m_lock[u] = g[u];
        end
      end else if (s_or[u] != 0) begin
        m_ov[u] = 0;
      end
    end
    @(posedge clock);
    #1;
    for (int u = 0; u < NU; u++) chk($sformatf("out_u%0d", u), obs_out(u), exp_out(u));
  endtask

  initial begin
    idle_all();
    for (int u = 0; u < NU; u++) begin
      m_ov[u] = 0; m_od[u] = 0; m_ol[u] = 0; m_os[u] = 0; m_ptr[u] = 0; m_lock[u] = -1;
    end

    // reset state
    reset = 1'b0;
    cycle();
    cycle();
    chk("rst_out0", obs_out(0), 0);
    chk("rst_out2", obs_out(2), 0);
    reset = 1'b1;

    // rotation, fixed priority and 3-channel wrap side by side
    s_v[0] = 15; s_l[0] = 15;
    s_v[1] = 6;  s_l[1] = 15;
    s_v[2] = 7;  s_l[2] = 7;
    for (int c = 0; c < 4; c++) begin
      s_d[0][c] = c + 1;
      s_d[1][c] = c + 1;
    end
    s_d[2][0] = 8'hC3; s_d[2][1] = 8'h5A; s_d[2][2] = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_sel", 32'(os0), 32'(k % 4));
      chk("rr_valid", 32'(ov0), 1);
      chk("fp_sel", 32'(os1), 1);
      chk("fp_rdy2", 32'(r1[2]), 0);
      chk("wrap_sel", 32'(os2), 32'(k % 3));
      if (k % 3 == 0) chk("wrap_data", 32'(od2), 32'h0C3);
    end

    idle_all();
    cycle();
    chk("drain_valid", 32'(ov0), 0);

    // packet lock: move ptr to 2, then ch2 sends a 3-beat packet with ch0 always valid
    s_v[0] = 2; s_l[0] = 2; s_d[0][1] = 4'h1;
    cycle();
    chk("lock_pre_sel", 32'(os0), 1);
    s_v[0] = 5; s_l[0] = 1; s_d[0][2] = 4'h7; s_d[0][0] = 4'h9;
    cycle();
    chk("lock_b0_sel", 32'(os0), 2);
    s_v[0] = 1;
    cycle();
    chk("lock_gap_valid", 32'(ov0), 0);
    chk("lock_gap_rdy", 32'(r0), 32'h4);
    s_v[0] = 5;
    cycle();
    chk("lock_b1_sel", 32'(os0), 2);
    s_l[0] = 5;
    cycle();
    chk("lock_b2_sel", 32'(os0), 2);
    chk("lock_b2_last", 32'(ol0), 1);
    s_v[0] = 1;
    cycle();
    chk("lock_after_sel", 32'(os0), 0);

    // backpressure holding 4'hA, then drain and accept in the same cycle
    s_v[0] = 1; s_l[0] = 1; s_d[0][0] = 4'hA;
    cycle();
    chk("bp_load", 32'(od0), 32'hA);
    s_or[0] = 0; s_d[0][0] = 4'h5;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_hold_data", 32'(od0), 32'hA);
      chk("bp_hold_valid", 32'(ov0), 1);
      chk("bp_hold_rdy", 32'(r0), 0);
    end
    s_or[0] = 1;
    cycle();
    chk("bp_next_data", 32'(od0), 32'h5);
    chk("bp_next_valid", 32'(ov0), 1);

    // reset in the middle of a ch1 packet
    s_v[0] = 2; s_l[0] = 0; s_d[0][1] = 4'h3;
    cycle();
    chk("rstmid_sel", 32'(os0), 1);
    reset = 1'b0;
    cycle();
    chk("rstmid_valid", 32'(ov0), 0);
    reset = 1'b1;
    s_v[0] = 3; s_l[0] = 15;
    cycle();
    chk("rstmid_after_sel", 32'(os0), 0);
    chk("rstmid_after_valid", 32'(ov0), 1);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int u = 0; u < NU; u++) begin
        int m;
        m = (1 << nch[u]) - 1;
        s_v[u]  = int'($urandom) & m;
        s_l[u]  = int'($urandom & $urandom) & m;
        s_or[u] = ($urandom_range(0, 3) != 0) ? 1 : 0;
        for (int c = 0; c < 4; c++) s_d[u][c] = int'($urandom) & dmask[u];
      end
      reset = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
